// File: rtl/edf_ar_scheduler_if.sv
// rtl/edf_ar_scheduler_if.sv - AR request/issue bundle for the EDF AR scheduler
interface edf_ar_scheduler_if #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 6,
    parameter int TS_WIDTH       = 16,
    parameter int MISS_CNT_WIDTH = 16
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]            s_arvalid;
    logic [NUM_PORTS-1:0]            s_arready;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] s_araddr;
    logic [NUM_PORTS*ID_WIDTH-1:0]   s_arid;
    logic [NUM_PORTS*8-1:0]          s_arlen;
    logic [NUM_PORTS*TS_WIDTH-1:0]   rel_deadline;
    logic                            m_arvalid;
    logic                            m_arready;
    logic [ADDR_WIDTH-1:0]           m_araddr;
    logic [ID_WIDTH-1:0]             m_arid;
    logic [7:0]                      m_arlen;
    logic [PW-1:0]                   m_arport;
    logic [TS_WIDTH-1:0]             m_ardeadline;
    logic [MISS_CNT_WIDTH-1:0]       miss_cnt;

    // scheduler side
    modport slave (
        input  s_arvalid, s_araddr, s_arid, s_arlen, rel_deadline, m_arready,
        output s_arready, m_arvalid, m_araddr, m_arid, m_arlen, m_arport, m_ardeadline, miss_cnt
    );

    // environment side: upstream requesters and downstream consumer
    modport master (
        output s_arvalid, s_araddr, s_arid, s_arlen, rel_deadline, m_arready,
        input  s_arready, m_arvalid, m_araddr, m_arid, m_arlen, m_arport, m_ardeadline, miss_cnt
    );
endinterface

// File: rtl/edf_ar_scheduler.sv
// rtl/edf_ar_scheduler.sv - earliest-deadline-first AR issue stage, optional EDF_MISS_CNT_EN miss counter
module edf_ar_scheduler #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 6,
    parameter int TS_WIDTH       = 16,
    parameter int MISS_CNT_WIDTH = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    edf_ar_scheduler_if.slave bus
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [TS_WIDTH-1:0]   ts;
    logic [NUM_PORTS-1:0]  slot_valid;
    logic [NUM_PORTS-1:0]  slot_valid_nxt;
    logic [NUM_PORTS-1:0]  ready_q;
    logic [NUM_PORTS-1:0]  accept;
    logic [ADDR_WIDTH-1:0] slot_addr [NUM_PORTS];
    logic [ID_WIDTH-1:0]   slot_id   [NUM_PORTS];
    logic [7:0]            slot_len  [NUM_PORTS];
    logic [TS_WIDTH-1:0]   slot_dl   [NUM_PORTS];

    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [ID_WIDTH-1:0]   out_id;
    logic [7:0]            out_len;
    logic [PW-1:0]         out_port;
    logic [TS_WIDTH-1:0]   out_dl;

    logic                  sel_found;
    logic [PW-1:0]         sel_idx;
    logic                  out_load;

    // wrap-safe "a before b": the modular difference is negative
    function automatic logic earlier(input logic [TS_WIDTH-1:0] a, input logic [TS_WIDTH-1:0] b);
        logic [TS_WIDTH-1:0] diff;
        diff = a - b;
        return diff[TS_WIDTH-1];
    endfunction

    assign accept   = bus.s_arvalid & ready_q;
    assign out_load = ~out_valid | bus.m_arready;

    // pick the earliest-deadline valid slot; strict compare keeps the lowest index on ties
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (slot_valid[i] && (!sel_found || earlier(slot_dl[i], slot_dl[sel_idx]))) begin
                sel_found = 1'b1;
                sel_idx   = PW'(i);
            end
        end
    end

    // slot occupancy after this edge: drain the winner, then fill accepted ports
    always_comb begin
        slot_valid_nxt = slot_valid;
        if (out_load && sel_found) slot_valid_nxt[sel_idx] = 1'b0;
        slot_valid_nxt = slot_valid_nxt | accept;
    end

    // timestamp, slot storage, and the registered output stage
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ts         <= '0;
            slot_valid <= '0;
            ready_q    <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_id     <= '0;
            out_len    <= '0;
            out_port   <= '0;
            out_dl     <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                slot_addr[i] <= '0;
                slot_id[i]   <= '0;
                slot_len[i]  <= '0;
                slot_dl[i]   <= '0;
            end
        end else begin
            ts         <= ts + 1'b1;
            slot_valid <= slot_valid_nxt;
            ready_q    <= ~slot_valid_nxt;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept[i]) begin
                    slot_addr[i] <= bus.s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    slot_id[i]   <= bus.s_arid[i*ID_WIDTH +: ID_WIDTH];
                    slot_len[i]  <= bus.s_arlen[i*8 +: 8];
                    slot_dl[i]   <= ts + bus.rel_deadline[i*TS_WIDTH +: TS_WIDTH];
                end
            end
            if (out_load) begin
                if (sel_found) begin
                    out_valid <= 1'b1;
                    out_addr  <= slot_addr[sel_idx];
                    out_id    <= slot_id[sel_idx];
                    out_len   <= slot_len[sel_idx];
                    out_port  <= sel_idx;
                    out_dl    <= slot_dl[sel_idx];
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.s_arready    = ready_q;
    assign bus.m_arvalid    = out_valid;
    assign bus.m_araddr     = out_addr;
    assign bus.m_arid       = out_id;
    assign bus.m_arlen      = out_len;
    assign bus.m_arport     = out_port;
    assign bus.m_ardeadline = out_dl;

`ifdef EDF_MISS_CNT_EN
    logic [MISS_CNT_WIDTH-1:0] miss_q;
    logic [TS_WIDTH-1:0]       late_by;
    logic                      late;

    assign late_by = ts - out_dl;
    assign late    = ~late_by[TS_WIDTH-1] && (late_by != '0);

    // count handshakes that complete strictly after their deadline, saturating
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            miss_q <= '0;
        end else if (out_valid && bus.m_arready && late && (miss_q != '1)) begin
            miss_q <= miss_q + 1'b1;
        end
    end

    assign bus.miss_cnt = miss_q;
`else
    assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_edf_ar_scheduler.sv
// tb/tb_edf_ar_scheduler.sv - directed self-checking bench for edf_ar_scheduler
module tb_edf_ar_scheduler;
    logic ACLK;
    logic ARESETN;
    int   n_tests;
    int   n_fail;
    logic [15:0] tb_ts;
    logic [15:0] t_a;
    logic [63:0] miss_exp;

    edf_ar_scheduler_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .ID_WIDTH(6), .TS_WIDTH(16), .MISS_CNT_WIDTH(16)) bus ();

    edf_ar_scheduler #(.NUM_PORTS(4), .ADDR_WIDTH(32), .ID_WIDTH(6), .TS_WIDTH(16), .MISS_CNT_WIDTH(16)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus.slave)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // reference timestamp: counts edges since reset release
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) tb_ts <= 16'd0;
        else          tb_ts <= tb_ts + 16'd1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [31:0] addr, input logic [5:0] id,
                            input logic [7:0] len, input logic [15:0] rel);
        bus.s_araddr[p*32 +: 32]     = addr;
        bus.s_arid[p*6 +: 6]         = id;
        bus.s_arlen[p*8 +: 8]        = len;
        bus.rel_deadline[p*16 +: 16] = rel;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] port, input logic [31:0] addr,
                           input logic [15:0] dl);
        chk({tag, "_valid"}, 64'(bus.m_arvalid), 64'd1);
        chk({tag, "_port"},  64'(bus.m_arport), 64'(port));
        chk({tag, "_addr"},  64'(bus.m_araddr), 64'(addr));
        chk({tag, "_dl"},    64'(bus.m_ardeadline), 64'(dl));
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
`ifdef EDF_MISS_CNT_EN
        miss_exp = 64'd1;
`else
        miss_exp = 64'd0;
`endif
        ARESETN          = 1'b0;
        bus.s_arvalid    = 4'hF;
        bus.s_araddr     = '0;
        bus.s_arid       = '0;
        bus.s_arlen      = '0;
        bus.rel_deadline = '0;
        bus.m_arready    = 1'b1;

        // 1: reset holds everything idle even with requests pending
        repeat (3) step();
        @(negedge ACLK);
        chk("rst_sready", 64'(bus.s_arready), 64'h0);
        chk("rst_mvalid", 64'(bus.m_arvalid), 64'h0);
        chk("rst_addr",   64'(bus.m_araddr), 64'h0);
        chk("rst_dl",     64'(bus.m_ardeadline), 64'h0);
        chk("rst_miss",   64'(bus.miss_cnt), 64'h0);
        step();
        ARESETN       = 1'b1;
        bus.s_arvalid = 4'h0;
        step();
        @(negedge ACLK);
        chk("rel_sready", 64'(bus.s_arready), 64'hF);

        // 2: single request from port 2 accepted at ts=10
        n = 0;
        while (tb_ts != 16'd10 && n < 100) begin step(); n++; end
        chk("wait_ts10", 64'(tb_ts), 64'd10);
        set_port(2, 32'h1000, 6'd5, 8'd7, 16'd50);
        bus.s_arvalid = 4'b0100;
        step();
        bus.s_arvalid = 4'b0000;
        @(negedge ACLK);
        chk("t2_latency", 64'(bus.m_arvalid), 64'd0);
        step();
        @(negedge ACLK);
        chk_out("t2", 2'd2, 32'h1000, 16'd60);
        chk("t2_id",  64'(bus.m_arid), 64'd5);
        chk("t2_len", 64'(bus.m_arlen), 64'd7);
        chk("t2_sready", 64'(bus.s_arready), 64'hF);
        step();
        @(negedge ACLK);
        chk("t2_pulse", 64'(bus.m_arvalid), 64'd0);

        // 3: earlier deadline on port 1 wins over port 0
        set_port(0, 32'h2000, 6'd1, 8'd0, 16'd100);
        set_port(1, 32'h2100, 6'd2, 8'd0, 16'd20);
        bus.s_arvalid = 4'b0011;
        step();
        bus.s_arvalid = 4'b0000;
        step();
        @(negedge ACLK);
        chk("t3_first_port", 64'(bus.m_arport), 64'd1);
        chk("t3_first_addr", 64'(bus.m_araddr), 64'h2100);
        step();
        @(negedge ACLK);
        chk("t3_second_valid", 64'(bus.m_arvalid), 64'd1);
        chk("t3_second_port",  64'(bus.m_arport), 64'd0);
        step();
        @(negedge ACLK);
        chk("t3_idle", 64'(bus.m_arvalid), 64'd0);

        // 4: equal deadlines resolve to the lower port
        set_port(1, 32'h3100, 6'd3, 8'd1, 16'd40);
        set_port(3, 32'h3300, 6'd4, 8'd1, 16'd40);
        bus.s_arvalid = 4'b1010;
        step();
        bus.s_arvalid = 4'b0000;
        step();
        @(negedge ACLK);
        chk("t4_first_port", 64'(bus.m_arport), 64'd1);
        step();
        @(negedge ACLK);
        chk("t4_second_port", 64'(bus.m_arport), 64'd3);
        chk("t4_second_addr", 64'(bus.m_araddr), 64'h3300);

        // 5: deadlines straddling the timestamp wrap
        n = 0;
        while (tb_ts != 16'hFFF0 && n < 70000) begin step(); n++; end
        chk("wait_tsfff0", 64'(tb_ts), 64'hFFF0);
        bus.m_arready = 1'b0;
        set_port(0, 32'h4000, 6'd0, 8'd0, 16'h0020);
        set_port(1, 32'h4100, 6'd0, 8'd0, 16'h0030);
        set_port(2, 32'h4200, 6'd0, 8'd0, 16'h000A);
        bus.s_arvalid = 4'b0111;
        step();
        bus.s_arvalid = 4'b0000;
        step();
        @(negedge ACLK);
        chk_out("t5_a", 2'd2, 32'h4200, 16'hFFFA);
        step();
        @(negedge ACLK);
        chk_out("t5_hold", 2'd2, 32'h4200, 16'hFFFA);
        bus.m_arready = 1'b1;
        step();
        @(negedge ACLK);
        chk_out("t5_b", 2'd0, 32'h4000, 16'h0010);
        step();
        @(negedge ACLK);
        chk_out("t5_c", 2'd1, 32'h4100, 16'h0020);
        step();
        @(negedge ACLK);
        chk("t5_idle", 64'(bus.m_arvalid), 64'd0);
        chk("t5_miss", 64'(bus.miss_cnt), 64'd0);

        // 6: stalled output stays stable, refilled slot blocks its port, late handshake counts
        step();
        bus.m_arready = 1'b0;
        t_a = tb_ts;
        set_port(0, 32'hA000, 6'd9, 8'd3, 16'd5);
        bus.s_arvalid = 4'b0001;
        step();
        set_port(0, 32'hB000, 6'd10, 8'd3, 16'd1000);
        step();
        step();
        bus.s_arvalid = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            chk_out("t6_stall", 2'd0, 32'hA000, t_a + 16'd5);
            chk("t6_sready0", 64'(bus.s_arready[0]), 64'd0);
            chk("t6_miss_pre", 64'(bus.miss_cnt), 64'd0);
            step();
        end
        bus.m_arready = 1'b1;
        step();
        @(negedge ACLK);
        chk_out("t6_next", 2'd0, 32'hB000, t_a + 16'd1002);
        chk("t6_miss", 64'(bus.miss_cnt), miss_exp);
        step();
        @(negedge ACLK);
        chk("t6_idle", 64'(bus.m_arvalid), 64'd0);
        chk("t6_miss_final", 64'(bus.miss_cnt), miss_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
